// File: rtl/rate_monitor_pkg.sv
// Shared packet-generator constants and types for the receive-side rate monitor.
// Wire overhead values match those used by the token-bucket limiter.
package rate_monitor_pkg;

  localparam int PREAMBLE      = 8;
  localparam int INTER_PKT_GAP = 12;
  localparam int FCS           = 4;

  localparam int unsigned IO_QUEUE_STAGE_NUM = 'hff;
  localparam int          IOQ_BYTE_LEN_POS   = 0;

  typedef enum logic [0:0] {
    ST_HDR,
    ST_PAYLOAD
  } parse_state_t;

  // Bytes a packet occupies on the wire, as the limiter accounts for it.
  function automatic logic [31:0] wire_bytes(input logic [31:0] len, input logic with_overhead);
    wire_bytes = len + 32'(FCS) + (with_overhead ? 32'(PREAMBLE + INTER_PKT_GAP) : 32'd0);
  endfunction

endpackage

// File: rtl/rate_monitor_if.sv
// NetFPGA module-bus word interface: data/ctrl/wr forward, rdy backward.
interface rate_monitor_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (output data, ctrl, wr, input rdy);
  modport slave  (input data, ctrl, wr, output rdy);
endinterface

// File: rtl/rate_monitor_window.sv
// Window counter, window_len change detect, saturating packet/byte accumulators
// and the end-of-window snapshot.
module rate_monitor_window #(
  parameter int WIN_WIDTH = 24,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIN_WIDTH-1:0] window_len,
  input  logic                 pkt_i,
  input  logic [CNT_WIDTH-1:0] pkt_bytes_i,
  output logic [CNT_WIDTH-1:0] win_pkts_o,
  output logic [CNT_WIDTH-1:0] win_bytes_o,
  output logic                 win_valid_o
);

  logic [WIN_WIDTH-1:0] win_cnt_q, win_cnt_d, win_len_prev_q;
  logic [CNT_WIDTH-1:0] pkts_acc_q, pkts_acc_d, bytes_acc_q, bytes_acc_d;
  logic [CNT_WIDTH-1:0] win_pkts_q, win_pkts_d, win_bytes_q, win_bytes_d;
  logic                 win_valid_q, win_valid_d;
  logic [CNT_WIDTH:0]   pkts_ext, bytes_ext;
  logic [CNT_WIDTH-1:0] pkts_sum, bytes_sum;
  logic                 len_changed, win_last;

  // One extra carry bit turns overflow into saturation at all-ones.
  assign pkts_ext  = {1'b0, pkts_acc_q} + (CNT_WIDTH+1)'(pkt_i);
  assign bytes_ext = {1'b0, bytes_acc_q} + (pkt_i ? {1'b0, pkt_bytes_i} : '0);
  assign pkts_sum  = pkts_ext[CNT_WIDTH]  ? '1 : pkts_ext[CNT_WIDTH-1:0];
  assign bytes_sum = bytes_ext[CNT_WIDTH] ? '1 : bytes_ext[CNT_WIDTH-1:0];

  assign len_changed = (window_len != win_len_prev_q);
  assign win_last    = (window_len != '0) && (win_cnt_q == window_len - WIN_WIDTH'(1));

  always_comb begin
    win_cnt_d   = win_cnt_q;
    pkts_acc_d  = pkts_acc_q;
    bytes_acc_d = bytes_acc_q;
    win_pkts_d  = win_pkts_q;
    win_bytes_d = win_bytes_q;
    win_valid_d = 1'b0;
    if (!enable || len_changed) begin
      win_cnt_d   = '0;
      pkts_acc_d  = '0;
      bytes_acc_d = '0;
    end else if (window_len == '0) begin
      win_cnt_d   = '0;
      pkts_acc_d  = pkts_sum;
      bytes_acc_d = bytes_sum;
    end else if (win_last) begin
      // A packet ending on the closing cycle belongs to the closing window.
      win_cnt_d   = '0;
      win_pkts_d  = pkts_sum;
      win_bytes_d = bytes_sum;
      pkts_acc_d  = '0;
      bytes_acc_d = '0;
      win_valid_d = 1'b1;
    end else begin
      win_cnt_d   = win_cnt_q + WIN_WIDTH'(1);
      pkts_acc_d  = pkts_sum;
      bytes_acc_d = bytes_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q      <= '0;
      win_len_prev_q <= '0;
      pkts_acc_q     <= '0;
      bytes_acc_q    <= '0;
      win_pkts_q     <= '0;
      win_bytes_q    <= '0;
      win_valid_q    <= 1'b0;
    end else begin
      win_cnt_q      <= win_cnt_d;
      win_len_prev_q <= window_len;
      pkts_acc_q     <= pkts_acc_d;
      bytes_acc_q    <= bytes_acc_d;
      win_pkts_q     <= win_pkts_d;
      win_bytes_q    <= win_bytes_d;
      win_valid_q    <= win_valid_d;
    end
  end

  assign win_pkts_o  = win_pkts_q;
  assign win_bytes_o = win_bytes_q;
  assign win_valid_o = win_valid_q;

endmodule

// File: rtl/rate_monitor.sv
// Inline receive-side rate meter: one-register bus pass-through, packet framing parser,
// inter-packet gap min/max tracking, and per-window packet/byte counts including wire overhead.
module rate_monitor
  import rate_monitor_pkg::*;
#(
  parameter int          DATA_WIDTH    = 64,
  parameter int          CTRL_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned IOQ_STAGE_NUM = IO_QUEUE_STAGE_NUM,
  parameter int          PKT_LEN_WIDTH = 11,
  parameter int          WIN_WIDTH     = 24,
  parameter int          CNT_WIDTH     = 32,
  parameter int          GAP_WIDTH     = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  rate_monitor_if.slave        in_bus,
  rate_monitor_if.master       out_bus,
  input  logic                 enable,
  input  logic                 include_overhead,
  input  logic [WIN_WIDTH-1:0] window_len,
  output logic [CNT_WIDTH-1:0] win_pkts,
  output logic [CNT_WIDTH-1:0] win_bytes,
  output logic                 win_valid,
  output logic [GAP_WIDTH-1:0] min_gap,
  output logic [GAP_WIDTH-1:0] max_gap
);

  logic [DATA_WIDTH-1:0]    out_data_q;
  logic [CTRL_WIDTH-1:0]    out_ctrl_q;
  logic                     out_wr_q;
  parse_state_t             state_q;
  logic                     hdr_seen_q, len_seen_q;
  logic [PKT_LEN_WIDTH-1:0] len_q;
  logic [GAP_WIDTH-1:0]     gap_q, min_gap_q, max_gap_q;
  logic                     gap_armed_q;
  logic                     ctrl_nz, is_ioq_hdr, eop, sop;
  logic [CNT_WIDTH-1:0]     pkt_bytes;

  assign in_bus.rdy = out_bus.rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q <= '0;
      out_ctrl_q <= '0;
      out_wr_q   <= 1'b0;
    end else begin
      out_data_q <= in_bus.data;
      out_ctrl_q <= in_bus.ctrl;
      out_wr_q   <= in_bus.wr;
    end
  end

  assign out_bus.data = out_data_q;
  assign out_bus.ctrl = out_ctrl_q;
  assign out_bus.wr   = out_wr_q;

  assign ctrl_nz    = |in_bus.ctrl;
  assign is_ioq_hdr = (in_bus.ctrl == CTRL_WIDTH'(IOQ_STAGE_NUM));
  assign eop        = in_bus.wr && (state_q == ST_PAYLOAD) && ctrl_nz;
  assign sop        = in_bus.wr && (state_q == ST_HDR) && !hdr_seen_q;
  assign pkt_bytes  = CNT_WIDTH'(wire_bytes(32'(len_q), include_overhead));

  // A ctrl==0 word only opens a payload once a header word has been seen, so after a
  // mid-packet reset the leftover words are swallowed as headers until their EOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_HDR;
      hdr_seen_q <= 1'b0;
      len_seen_q <= 1'b0;
      len_q      <= '0;
    end else if (in_bus.wr) begin
      case (state_q)
        ST_HDR: begin
          if (!ctrl_nz) begin
            if (hdr_seen_q) state_q <= ST_PAYLOAD;
          end else begin
            hdr_seen_q <= 1'b1;
            if (is_ioq_hdr && !len_seen_q) begin
              len_q      <= in_bus.data[IOQ_BYTE_LEN_POS +: PKT_LEN_WIDTH];
              len_seen_q <= 1'b1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (ctrl_nz) begin
            state_q    <= ST_HDR;
            hdr_seen_q <= 1'b0;
            len_seen_q <= 1'b0;
            len_q      <= '0;
          end
        end
        default: state_q <= ST_HDR;
      endcase
    end
  end

  // Gap is the number of idle clocks between an EOP and the next packet's first word.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      gap_q       <= '0;
      gap_armed_q <= 1'b0;
      min_gap_q   <= '1;
      max_gap_q   <= '0;
    end else begin
      if (eop) begin
        gap_q       <= '0;
        gap_armed_q <= 1'b1;
      end else if (gap_q != '1) begin
        gap_q <= gap_q + GAP_WIDTH'(1);
      end
      if (sop && gap_armed_q) begin
        gap_armed_q <= 1'b0;
        if (gap_q < min_gap_q) min_gap_q <= gap_q;
        if (gap_q > max_gap_q) max_gap_q <= gap_q;
      end
    end
  end

  assign min_gap = min_gap_q;
  assign max_gap = max_gap_q;

  rate_monitor_window #(
    .WIN_WIDTH (WIN_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_window (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .window_len  (window_len),
    .pkt_i       (eop && enable),
    .pkt_bytes_i (pkt_bytes),
    .win_pkts_o  (win_pkts),
    .win_bytes_o (win_bytes),
    .win_valid_o (win_valid)
  );

endmodule

// File: tb/tb_rate_monitor.sv
// Scoreboard bench for rate_monitor: the driver queues expected pass-through words and
// window snapshots; a negedge monitor pops and compares whenever the DUT presents them.
module tb_rate_monitor;

  localparam int GW = 12;  // narrow gap counter so saturation is reachable quickly

  logic          clk = 1'b0;
  logic          reset;
  logic          enable, include_overhead;
  logic [23:0]   window_len;
  logic [31:0]   win_pkts, win_bytes;
  logic          win_valid;
  logic [GW-1:0] min_gap, max_gap;
  logic          rdy_toggle;
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            pkt_seq = 0;

  rate_monitor_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) in_if ();
  rate_monitor_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) out_if ();

  rate_monitor #(.GAP_WIDTH(GW)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_bus           (in_if),
    .out_bus          (out_if),
    .enable           (enable),
    .include_overhead (include_overhead),
    .window_len       (window_len),
    .win_pkts         (win_pkts),
    .win_bytes        (win_bytes),
    .win_valid        (win_valid),
    .min_gap          (min_gap),
    .max_gap          (max_gap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  ctrl;
  } pt_t;

  typedef struct {
    logic [31:0] pkts;
    logic [31:0] bytes;
    int          cyc;
  } win_t;

  pt_t  pt_q[$];
  win_t win_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks rdy passthrough every cycle, pops scoreboards on out_wr / win_valid.
  pt_t  mp;
  win_t mw;
  always @(negedge clk) begin
    chk("in_rdy", 64'(in_if.rdy), 64'(out_if.rdy));
    if (out_if.wr === 1'b1) begin
      if (pt_q.size() == 0) begin
        chk("out_wr_unexpected", 64'(out_if.wr), 64'd0);
      end else begin
        mp = pt_q.pop_front();
        chk("out_data", out_if.data, mp.data);
        chk("out_ctrl", 64'(out_if.ctrl), 64'(mp.ctrl));
      end
    end
    if (win_valid === 1'b1) begin
      $display("[TB] window closed @%0d: pkts=%0d bytes=%0d", cyc, win_pkts, win_bytes);
      if (win_q.size() == 0) begin
        chk("win_valid_unexpected", 64'(win_valid), 64'd0);
      end else begin
        mw = win_q.pop_front();
        chk("win_pkts", 64'(win_pkts), 64'(mw.pkts));
        chk("win_bytes", 64'(win_bytes), 64'(mw.bytes));
        chk("win_cycle", 64'(cyc), 64'(mw.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_toggle) out_if.rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_word(input logic [63:0] d, input logic [7:0] c, input bit expect_out);
    in_if.data = d;
    in_if.ctrl = c;
    in_if.wr   = 1'b1;
    if (expect_out) pt_q.push_back('{data: d, ctrl: c});
    tick();
  endtask

  // IOQ header carrying len, then 7 payload words and an EOP word.
  task automatic send_pkt(input int len);
    pkt_seq++;
    $display("[TB] packet %0d len=%0d start @%0d", pkt_seq, len, cyc);
    drive_word({32'(pkt_seq), 32'(len)}, 8'hff, 1'b1);
    for (int i = 0; i < 8; i++)
      drive_word({32'(pkt_seq) ^ 32'hA5A5_0000, 32'(i * 7 + 3)}, (i == 7) ? 8'h10 : 8'h00, 1'b1);
    in_if.wr = 1'b0;
  endtask

  task automatic expect_win(input int pkts, input int bytes, input int at);
    win_q.push_back('{pkts: 32'(pkts), bytes: 32'(bytes), cyc: at});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, m;
    reset = 1'b1; enable = 1'b0; include_overhead = 1'b0; window_len = 24'd1000;
    rdy_toggle = 1'b0; out_if.rdy = 1'b1;
    in_if.data = '0; in_if.ctrl = '0; in_if.wr = 1'b0;
    idle(3);
    chk("rst_out_wr", 64'(out_if.wr), 64'd0);
    chk("rst_out_data", out_if.data, 64'd0);
    chk("rst_win_valid", 64'(win_valid), 64'd0);
    chk("rst_win_pkts", 64'(win_pkts), 64'd0);
    chk("rst_win_bytes", 64'(win_bytes), 64'd0);
    chk("rst_min_gap", 64'(min_gap), 64'hFFF);
    chk("rst_max_gap", 64'(max_gap), 64'd0);
    reset = 1'b0;
    idle(2);

    // 1: ten 60 B packets in a 1000-cycle window, no overhead
    n = cyc; enable = 1'b1;
    expect_win(10, 640, n + 1000);
    for (int i = 0; i < 10; i++) begin send_pkt(60); idle(2); end
    wait_cyc(n + 1002);
    chk("t1_min_gap", 64'(min_gap), 64'd2);
    chk("t1_max_gap", 64'(max_gap), 64'd2);
    enable = 1'b0; idle(2);

    // 2: same traffic with overhead, downstream ready toggling
    include_overhead = 1'b1; rdy_toggle = 1'b1;
    n = cyc; enable = 1'b1;
    expect_win(10, 840, n + 1000);
    for (int i = 0; i < 10; i++) begin send_pkt(60); idle(2); end
    wait_cyc(n + 1002);
    enable = 1'b0; rdy_toggle = 1'b0; out_if.rdy = 1'b1; include_overhead = 1'b0;
    idle(2);

    // 3: EOP on the closing cycle of a 100-cycle window
    window_len = 24'd100; idle(2);
    n = cyc; enable = 1'b1;
    expect_win(1, 64, n + 100);
    expect_win(0, 0, n + 200);
    wait_cyc(n + 91);
    send_pkt(60);
    wait_cyc(n + 203);
    enable = 1'b0; idle(2);

    // window_len = 1 closes every clock
    window_len = 24'd1; idle(2);
    n = cyc; enable = 1'b1;
    expect_win(0, 0, n + 1); expect_win(0, 0, n + 2); expect_win(0, 0, n + 3);
    idle(3);
    enable = 1'b0; idle(3);

    // 4: gaps 5, 17, 9 then a saturating gap, no snapshots
    window_len = 24'd0; idle(2);
    enable = 1'b1;
    send_pkt(60); idle(5);
    send_pkt(60); idle(17);
    send_pkt(60); idle(9);
    send_pkt(60); idle(2);
    chk("t4_min_gap", 64'(min_gap), 64'd5);
    chk("t4_max_gap", 64'(max_gap), 64'd17);
    idle(4200);
    send_pkt(60); idle(2);
    chk("t4_max_gap_sat", 64'(max_gap), 64'hFFF);
    chk("t4_min_gap_keep", 64'(min_gap), 64'd5);
    enable = 1'b0; idle(2);
    chk("t4_min_gap_off", 64'(min_gap), 64'hFFF);
    chk("t4_max_gap_off", 64'(max_gap), 64'd0);

    // 5: window_len change mid-window restarts with no snapshot
    window_len = 24'd200; idle(2);
    n = cyc; enable = 1'b1;
    send_pkt(60); idle(3); send_pkt(60);
    wait_cyc(n + 50);
    m = cyc; window_len = 24'd150;
    expect_win(1, 104, m + 151);
    send_pkt(100);
    wait_cyc(m + 160);
    enable = 1'b0; idle(2);
    chk("t5_win_pkts_held", 64'(win_pkts), 64'd1);
    chk("t5_win_bytes_held", 64'(win_bytes), 64'd104);
    chk("t5_min_gap_off", 64'(min_gap), 64'hFFF);

    // 6: reset in mid-packet; only the following complete packet counts
    window_len = 24'd300; idle(2);
    drive_word(64'h1111_0000_0000_003C, 8'hff, 1'b1);
    drive_word(64'h2222_2222_2222_2222, 8'h00, 1'b1);
    drive_word(64'h3333_3333_3333_3333, 8'h00, 1'b1);
    reset = 1'b1;
    drive_word(64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 1'b0);
    chk("t6_out_wr_after_reset", 64'(out_if.wr), 64'd0);
    reset = 1'b0; in_if.wr = 1'b0;
    tick();
    n = cyc; enable = 1'b1;
    expect_win(1, 64, n + 300);
    drive_word(64'h4444_4444_4444_4444, 8'h00, 1'b1);
    drive_word(64'h5555_5555_5555_5555, 8'h00, 1'b1);
    drive_word(64'h6666_6666_6666_6666, 8'h04, 1'b1);
    in_if.wr = 1'b0;
    idle(2);
    send_pkt(60);
    wait_cyc(n + 303);
    enable = 1'b0; idle(3);

    chk("pt_queue_drained", 64'(pt_q.size()), 64'd0);
    chk("win_queue_drained", 64'(win_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
